// File: rtl/data_mem_responder_if.sv
// Load/store port bundle between the core datapath
// and the data memory responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_size, req_unsigned,
    output resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_size, req_unsigned,
    input  resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with
// fixed latency, byte lanes and error flagging.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t nxt;

  logic [3:0]  cnt;
  logic        we;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        err;
  logic        fire;
  logic [31:0] ld;

  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [7:0] by0, by1, by2, by3;

  logic [7:0] mem [2**ADDR_WIDTH];

  assign a0 = addr[ADDR_WIDTH-1:0];
  assign a1 = a0 + ADDR_WIDTH'(1);
  assign a2 = a0 + ADDR_WIDTH'(2);
  assign a3 = a0 + ADDR_WIDTH'(3);

  assign by0 = mem[a0];
  assign by1 = mem[a1];
  assign by2 = mem[a2];
  assign by3 = mem[a3];

  assign err = (size == 2'd3)
            || (size == 2'd1 && addr[0])
            || (size == 2'd2 && addr[1:0] != 2'd0)
            || (|addr[31:ADDR_WIDTH]);

  assign fire = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.req_valid)  nxt = WAIT;
      WAIT:    if (cnt == 4'd0)    nxt = RESP;
      RESP:    if (bus.resp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ld = '0;
    unique case (size)
      2'd0: ld = uns ? {24'h0, by0}
                     : {{24{by0[7]}}, by0};
      2'd1: ld = uns ? {16'h0, by1, by0}
                     : {{16{by1[7]}}, by1, by0};
      2'd2: ld = {by3, by2, by1, by0};
      default: ld = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      we      <= 1'b0;
      uns     <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      size    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        we    <= bus.req_we;
        uns   <= bus.req_unsigned;
        addr  <= bus.req_addr;
        wdata <= bus.req_wdata;
        size  <= bus.req_size;
        cnt   <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (fire) begin
        rdata_q <= (err || we) ? 32'h0 : ld;
        err_q   <= err;
      end
    end
  end

  // RAM is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (!rst && fire && we && !err) begin
      mem[a0] <= wdata[7:0];
      if (size != 2'd0) mem[a1] <= wdata[15:8];
      if (size == 2'd2) begin
        mem[a2] <= wdata[23:16];
        mem[a3] <= wdata[31:24];
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for the data memory
// responder, checked against a byte-array model.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  data_mem_responder_if b0 ();
  data_mem_responder_if b1 ();

  data_mem_responder #(.ADDR_WIDTH(17), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .bus(b0)
  );

  data_mem_responder #(.ADDR_WIDTH(17), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rmem [int];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(
    input logic w, input logic [31:0] a,
    input logic [31:0] d, input logic [1:0] s,
    input logic u,
    output logic [31:0] rd, output logic e);
    int n;
    logic [31:0] v;
    n  = 1 << s;
    e  = (s == 2'd3) || (a % n != 0) || (a >= 32'h20000);
    rd = 32'h0;
    v  = 32'h0;
    if (e) return;
    for (int i = 0; i < n; i++) begin
      if (w) rmem[int'(a) + i] = d[8*i +: 8];
      else   v = v | (32'(rmem[int'(a) + i]) << (8*i));
    end
    if (!w && !u && n < 4 && v[8*n-1])
      v = v | ~((32'h1 << (8*n)) - 32'h1);
    if (!w) rd = v;
  endfunction

  task automatic drive(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s,
                       input logic u);
    b0.req_we = w;
    b0.req_addr = a;
    b0.req_wdata = d;
    b0.req_size = s;
    b0.req_unsigned = u;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!b0.resp_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_req(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] s,
                        input logic u, input string tag);
    logic [31:0] erd;
    logic ee;
    int n;
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(b0.req_ready), 32'h1);
    drive(w, a, d, s, u);
    b0.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.req_valid = 1'b0;
    wait_resp(n);
    model(w, a, d, s, u, erd, ee);
    chk({tag, ".lat"}, n, 2);
    chk({tag, ".rdata"}, b0.resp_rdata, erd);
    chk({tag, ".err"}, 32'(b0.resp_err), 32'(ee));
    b0.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.resp_ready = 1'b0;
    chk({tag, ".idle"}, 32'(b0.req_ready), 32'h1);
  endtask

  logic [31:0] exp_d;
  logic        exp_e;
  int          nl;
  logic [31:0] ta [16];
  logic [31:0] td [16];
  logic        tw [16];
  int          acc [$];
  logic [31:0] got [$];

  initial begin
    b0.req_valid = 1'b0; b0.resp_ready = 1'b0;
    b1.req_valid = 1'b0; b1.resp_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    b1.req_we = 1'b0; b1.req_addr = '0;
    b1.req_wdata = '0; b1.req_size = 2'd2;
    b1.req_unsigned = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rdy", 32'(b0.req_ready), 32'h1);
    chk("rst.vld", 32'(b0.resp_valid), 32'h0);
    chk("rst.rdata", b0.resp_rdata, 32'h0);
    chk("rst.err", 32'(b0.resp_err), 32'h0);
    rst = 1'b0;

    do_req(1, 32'h100, 32'hDEADBEEF, 2, 0, "st_w");
    do_req(0, 32'h100, 32'h0, 2, 0, "ld_w");
    do_req(0, 32'h103, 32'h0, 0, 0, "ld_bs");
    do_req(0, 32'h103, 32'h0, 0, 1, "ld_bu");
    do_req(0, 32'h100, 32'h0, 1, 0, "ld_hs");
    do_req(0, 32'h102, 32'h0, 1, 1, "ld_hu");
    do_req(1, 32'h101, 32'h12, 0, 0, "st_b");
    do_req(0, 32'h100, 32'h0, 2, 1, "ld_w2");
    chk("st_b.const", b0.resp_rdata, 32'hDEAD12EF);
    do_req(0, 32'h102, 32'h0, 2, 0, "e_misw");
    do_req(1, 32'h101, 32'hAAAA, 1, 0, "e_mish");
    do_req(0, 32'h100, 32'h0, 3, 0, "e_size");
    do_req(0, 32'h20000, 32'h0, 2, 0, "e_range");
    do_req(1, 32'h20100, 32'h0, 2, 0, "e_rng_st");
    do_req(0, 32'h100, 32'h0, 2, 0, "ld_after_e");

    do_req(1, 32'h200, 32'h11223344, 2, 0, "pre_200");
    @(negedge clk);
    drive(1, 32'h200, 32'h55555555, 2, 0);
    b0.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rwait.rdy", 32'(b0.req_ready), 32'h1);
    chk("rwait.vld", 32'(b0.resp_valid), 32'h0);
    do_req(0, 32'h200, 32'h0, 2, 0, "ld_200");

    @(negedge clk);
    drive(0, 32'h100, 32'h0, 2, 0);
    b0.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.req_valid = 1'b0;
    wait_resp(nl);
    model(0, 32'h100, 32'h0, 2, 0, exp_d, exp_e);
    chk("bp.lat", nl, 2);
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h100, 32'h0, 2, 0);
      b0.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp.vld", 32'(b0.resp_valid), 32'h1);
      chk("bp.rdata", b0.resp_rdata, exp_d);
      chk("bp.rdy", 32'(b0.req_ready), 32'h0);
    end
    b0.req_valid = 1'b0;
    b0.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.resp_ready = 1'b0;
    chk("bp.rel_rdy", 32'(b0.req_ready), 32'h1);
    chk("bp.rel_vld", 32'(b0.resp_valid), 32'h0);
    do_req(0, 32'h100, 32'h0, 2, 0, "bp.unchg");

    for (int i = 0; i < 16; i++)
      do_req(1, 32'h300 + 32'(4*i), $urandom, 2, 0, "fill");
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int sel;
      sel = int'($urandom % 8);
      a = 32'h300 + ($urandom % 64);
      if (sel == 0) a = a | 32'h20000;
      if (sel == 1) a = a | 32'h80000000;
      do_req(1'($urandom), a, $urandom,
             2'($urandom), 1'($urandom), "rnd");
    end

    for (int k = 0; k < 16; k++) begin
      tw[k] = (k < 8);
      ta[k] = 32'h40 + 32'(4 * (k % 8));
      td[k] = $urandom;
    end
    b1.resp_ready = 1'b1;
    begin
      int k;
      k = 0;
      @(negedge clk);
      for (int c = 0; c < 200 && got.size() < 16; c++) begin
        if (b1.resp_valid) got.push_back(b1.resp_rdata);
        if (b1.req_ready && k < 16) begin
          b1.req_we = tw[k];
          b1.req_addr = ta[k];
          b1.req_wdata = td[k];
          b1.req_valid = 1'b1;
          acc.push_back(cyc);
          k++;
        end else if (k >= 16) begin
          b1.req_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
      end
    end
    b1.req_valid = 1'b0;
    chk("tp.count", got.size(), 16);
    for (int k = 1; k < acc.size(); k++)
      chk("tp.gap", acc[k] - acc[k-1], 3);
    for (int k = 0; k < 16 && k < got.size(); k++)
      chk("tp.data", got[k], tw[k] ? 32'h0 : td[k-8]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
